// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, letter codes, tick thresholds and the
// pattern-to-letter table, used by both the decoder and the transmitter.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MARK   = 2'd1,
        ST_SPACE  = 2'd2,
        ST_DECODE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        LTR_A = 3'd0,
        LTR_B = 3'd1,
        LTR_C = 3'd2,
        LTR_D = 3'd3,
        LTR_E = 3'd4,
        LTR_F = 3'd5,
        LTR_G = 3'd6,
        LTR_H = 3'd7
    } letter_e;

    // Mark lengths up to DOT_MAX are dots, up to DASH_MAX are dashes.
    localparam logic [2:0] DOT_MAX_TICKS  = 3'd2;
    localparam logic [2:0] DASH_MAX_TICKS = 3'd5;
    localparam logic [2:0] GAP_TICKS      = 3'd3;
    localparam logic [2:0] TICK_SAT       = 3'd7;
    localparam logic [2:0] MAX_SYMBOLS    = 3'd4;

    typedef struct packed {
        logic    ok;
        letter_e code;
    } decode_t;

    // Symbols are shifted in at bit 0, so the first symbol sits at bit count-1.
    function automatic decode_t decode_pattern(input logic [3:0] pattern,
                                               input logic [2:0] count);
        decode_t res;
        res.ok   = 1'b1;
        res.code = LTR_A;
        case ({count, pattern})
            {3'd2, 4'b0001}: res.code = LTR_A;
            {3'd4, 4'b1000}: res.code = LTR_B;
            {3'd4, 4'b1010}: res.code = LTR_C;
            {3'd3, 4'b0100}: res.code = LTR_D;
            {3'd1, 4'b0000}: res.code = LTR_E;
            {3'd4, 4'b0010}: res.code = LTR_F;
            {3'd3, 4'b0110}: res.code = LTR_G;
            {3'd4, 4'b0000}: res.code = LTR_H;
            default:         res.ok   = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Free-running time-unit divider: tick pulses for one clk cycle every
// TICK_CYCLES cycles, counting from reset release.
module morse_tick_gen #(
    parameter int unsigned TICK_CYCLES = 25000000
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder for letters A-H: synchronizes the key, times marks and
// gaps in tick units, and emits a letter or an error pulse per character.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_n,
    output logic [2:0] letter,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    logic       tick;
    logic       pressed;
    state_e     state_q, state_d;
    logic       key_meta_q, key_meta_d;
    logic       key_sync_q, key_sync_d;
    logic [2:0] tick_cnt_q, tick_cnt_d;
    logic [3:0] pattern_q, pattern_d;
    logic [2:0] sym_cnt_q, sym_cnt_d;
    logic [2:0] letter_q, letter_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    decode_t    dec;

    morse_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
        .clk   (clk),
        .resetn(resetn),
        .tick  (tick)
    );

    assign pressed = ~key_sync_q;
    assign dec     = decode_pattern(pattern_q, sym_cnt_q);

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        key_meta_d = key_n;
        key_sync_d = key_meta_q;
        state_d    = state_q;
        pattern_d  = pattern_q;
        sym_cnt_d  = sym_cnt_q;
        letter_d   = letter_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pattern_d = '0;
                sym_cnt_d = '0;
                if (pressed) state_d = ST_MARK;
            end
            ST_MARK: begin
                if (!pressed) begin
                    if (tick_cnt_q == 3'd0) begin
                        state_d = (sym_cnt_q != 3'd0) ? ST_SPACE : ST_IDLE;
                    end else if (tick_cnt_q > DASH_MAX_TICKS || sym_cnt_q == MAX_SYMBOLS) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        pattern_d = {pattern_q[2:0], (tick_cnt_q > DOT_MAX_TICKS)};
                        sym_cnt_d = sym_cnt_q + 3'd1;
                        state_d   = ST_SPACE;
                    end
                end
            end
            ST_SPACE: begin
                // The gap check wins, so a press landing on the decode cycle is ignored.
                if (tick_cnt_q >= GAP_TICKS) state_d = ST_DECODE;
                else if (pressed)            state_d = ST_MARK;
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (dec.ok) begin
                    valid_d  = 1'b1;
                    letter_d = dec.code;
                end else begin
                    error_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tick_cnt_d = tick_cnt_q;
        if (state_d != state_q) begin
            tick_cnt_d = '0;
        end else if (tick && (state_q == ST_MARK || state_q == ST_SPACE)
                     && tick_cnt_q != TICK_SAT) begin
            tick_cnt_d = tick_cnt_q + 3'd1;
        end
    end

    // Synchronizer flops reset to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            tick_cnt_q <= '0;
            pattern_q  <= '0;
            sym_cnt_q  <= '0;
            letter_q   <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            tick_cnt_q <= tick_cnt_d;
            pattern_q  <= pattern_d;
            sym_cnt_q  <= sym_cnt_d;
            letter_q   <= letter_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign letter = letter_q;
    assign valid  = valid_q;
    assign error  = error_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: directed key sequences plus random
// letters, compared against a per-character model of expected pulses.
module tb_morse_decoder;

    localparam int N = 5;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       key_n  = 1'b1;
    logic [2:0] letter;
    logic       valid;
    logic       error;
    logic       busy;

    morse_decoder #(.TICK_CYCLES(N)) dut (
        .clk   (clk),
        .resetn(resetn),
        .key_n (key_n),
        .letter(letter),
        .valid (valid),
        .error (error),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the divider ticks land on multiples of N.
    int cyc;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        bit is_err;
        int code;
    } exp_t;

    exp_t exp_q[$];
    int   ltr_table[string];
    int   model_letter = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int lookup(input string p);
        if (ltr_table.exists(p)) return ltr_table[p];
        return -1;
    endfunction

    task automatic push_valid(input int code);
        exp_t e;
        e.is_err = 1'b0;
        e.code   = code;
        exp_q.push_back(e);
    endtask

    task automatic push_error();
        exp_t e;
        e.is_err = 1'b1;
        e.code   = 0;
        exp_q.push_back(e);
    endtask

    // Compare process: every cycle the outputs are checked against the model.
    always @(negedge clk) begin
        if (!resetn) begin
            check("rst_letter", int'(letter), 0);
            check("rst_valid", int'(valid), 0);
            check("rst_error", int'(error), 0);
            check("rst_busy", int'(busy), 0);
            model_letter = 0;
            exp_q.delete();
        end else begin
            check("valid_error_exclusive", int'(valid && error), 0);
            if (valid || error) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", int'(valid || error), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_valid", int'(valid), int'(!e.is_err));
                    check("pulse_error", int'(error), int'(e.is_err));
                    if (!e.is_err) begin
                        check("pulse_letter", int'(letter), e.code);
                        model_letter = e.code;
                    end
                end
            end else begin
                check("letter_hold", int'(letter), model_letter);
            end
        end
    end

    // Drivers: called at a negedge whose edge count is a multiple of N.
    task automatic press(input int ticks);
        key_n = 1'b0;
        repeat (ticks * N) @(negedge clk);
        key_n = 1'b1;
    endtask

    task automatic gap(input int ticks);
        key_n = 1'b1;
        repeat (ticks * N) @(negedge clk);
    endtask

    // Release ~1 tick, a 2-cycle bounce clear of any tick, then realign and wait.
    task automatic glitch_gap(input int after_ticks);
        key_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        key_n = 1'b0;
        repeat (2) @(negedge clk);
        key_n = 1'b1;
        while (cyc % N != 0) @(negedge clk);
        repeat (after_ticks * N) @(negedge clk);
    endtask

    task automatic quiet_point(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic random_letter();
        int    n, cnt, nlast, code, g;
        int    t[5];
        bit    err;
        string pat;
        n     = int'($urandom_range(1, 5));
        nlast = n - 1;
        cnt   = 0;
        err   = 1'b0;
        pat   = "";
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0)     t[i] = int'($urandom_range(6, 7));
            else if ($urandom_range(0, 1) == 1) t[i] = int'($urandom_range(1, 2));
            else                                t[i] = int'($urandom_range(3, 5));
        end
        for (int i = 0; i < n; i++) begin
            if (t[i] >= 6 || cnt == 4) begin
                err   = 1'b1;
                nlast = i;
                break;
            end
            pat = {pat, (t[i] <= 2) ? "." : "-"};
            cnt++;
        end
        if (!err) begin
            code = lookup(pat);
            err  = (code < 0);
        end
        if (err) push_error();
        else     push_valid(code);

        for (int i = 0; i <= nlast; i++) begin
            press(t[i]);
            if (i < nlast) begin
                if ($urandom_range(0, 4) == 0) glitch_gap(1);
                else                           gap(int'($urandom_range(1, 2)));
            end
        end
        g = int'($urandom_range(3, 5));
        if ($urandom_range(0, 3) == 0) glitch_gap(g);
        else                           gap(g);
        if (g >= 4) quiet_point("rand");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ltr_table[".-"]   = 0;
        ltr_table["-..."] = 1;
        ltr_table["-.-."] = 2;
        ltr_table["-.."]  = 3;
        ltr_table["."]    = 4;
        ltr_table["..-."] = 5;
        ltr_table["--."]  = 6;
        ltr_table["...."] = 7;

        check("model_B", lookup("-..."), 1);
        check("model_H", lookup("...."), 7);
        check("model_unmapped", lookup("----"), -1);

        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        check("init_letter", int'(letter), 0);
        check("init_busy", int'(busy), 0);
        gap(2);

        // E: one-tick mark then a full gap.
        push_valid(4);
        press(1); gap(4);
        quiet_point("e");
        check("e_letter", int'(letter), 4);

        // B: -...
        push_valid(1);
        press(3); gap(1); press(1); gap(1); press(1); gap(1); press(1); gap(4);
        quiet_point("b");
        check("b_letter", int'(letter), 1);

        // Over-long mark.
        push_error();
        press(7); gap(4);
        quiet_point("long");
        check("long_letter_kept", int'(letter), 1);

        // Five dots, then the unmapped ----.
        push_error();
        for (int i = 0; i < 4; i++) begin press(1); gap(1); end
        press(1); gap(4);
        quiet_point("five");
        push_error();
        for (int i = 0; i < 3; i++) begin press(3); gap(1); end
        press(3); gap(4);
        quiet_point("dashes");

        // D with a bounce in the middle of the second gap.
        push_valid(3);
        press(3); gap(1); press(1); glitch_gap(1); press(1); gap(4);
        quiet_point("glitch");
        check("d_letter", int'(letter), 3);

        // Reset during the third symbol of C discards it silently.
        press(3); gap(1); press(1); gap(1);
        key_n = 1'b0;
        repeat (N + 2) @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        key_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_letter", int'(letter), 0);
        check("midrst_busy", int'(busy), 0);
        @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        push_valid(0);
        press(1); gap(1); press(3); gap(4);
        quiet_point("a");
        check("a_letter", int'(letter), 0);

        // Back-to-back letters with the minimum gap: G then E, press held into IDLE.
        push_valid(6);
        push_valid(4);
        press(3); gap(1); press(3); gap(1); press(1); gap(3);
        press(2); gap(4);
        quiet_point("b2b");
        check("b2b_letter", int'(letter), 4);

        for (int k = 0; k < 40; k++) random_letter();

        gap(5);
        quiet_point("end");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
